// File: rtl/id_exe.sv
// ID->EXE pipeline register for the 5-stage RV32I core.
// Captures decoded ID outputs, applies the flush/hold/bubble controls,
// feeds the load-use indication back to ID, and counts inserted bubbles.
module id_exe #(
  parameter int          ADDR_WIDTH  = 32,
  parameter int          DATA_WIDTH  = 32,
  parameter int          RADDR_WIDTH = 5,
  parameter logic [31:0] NOP_INST    = 32'h00000013,
  parameter int          CNT_WIDTH   = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   stall_id_i,
  input  logic                   stall_exe_i,
  input  logic                   flush_i,
  input  logic [DATA_WIDTH-1:0]  inst_i,
  input  logic [ADDR_WIDTH-1:0]  inst_addr_i,
  input  logic [DATA_WIDTH-1:0]  op1_i,
  input  logic [DATA_WIDTH-1:0]  op2_i,
  input  logic                   reg_we_i,
  input  logic [RADDR_WIDTH-1:0] reg_waddr_i,
  output logic [DATA_WIDTH-1:0]  inst_o,
  output logic [ADDR_WIDTH-1:0]  inst_addr_o,
  output logic [DATA_WIDTH-1:0]  op1_o,
  output logic [DATA_WIDTH-1:0]  op2_o,
  output logic                   reg_we_o,
  output logic [RADDR_WIDTH-1:0] reg_waddr_o,
  output logic                   valid_o,
  output logic                   pre_inst_is_load_o,
  output logic [RADDR_WIDTH-1:0] exe_rd_o,
  output logic [CNT_WIDTH-1:0]   bubble_cnt_o
);

  localparam logic [6:0] OPC_LOAD = 7'b0000011;

  logic load_bubble;
  logic is_load;
  logic cnt_sat;

  // A bubble is loaded on a flush, or on an ID stall when EXE is free to advance.
  always_comb begin
    load_bubble = flush_i | (stall_id_i & ~stall_exe_i);
    is_load     = (inst_i[6:0] == OPC_LOAD) & reg_we_i & (reg_waddr_i != '0);
    cnt_sat     = (bubble_cnt_o == {CNT_WIDTH{1'b1}});
  end

  // Pipeline payload: reset/bubble to NOP state, hold on EXE stall, else capture.
  always_ff @(posedge clk_i) begin
    if (!rst_i || load_bubble) begin
      inst_o             <= NOP_INST[DATA_WIDTH-1:0];
      inst_addr_o        <= '0;
      op1_o              <= '0;
      op2_o              <= '0;
      reg_we_o           <= 1'b0;
      reg_waddr_o        <= '0;
      valid_o            <= 1'b0;
      pre_inst_is_load_o <= 1'b0;
    end else if (!stall_exe_i) begin
      inst_o             <= inst_i;
      inst_addr_o        <= inst_addr_i;
      op1_o              <= op1_i;
      op2_o              <= op2_i;
      reg_we_o           <= reg_we_i;
      reg_waddr_o        <= reg_waddr_i;
      valid_o            <= 1'b1;
      pre_inst_is_load_o <= is_load;
    end
  end

  // Saturating count of inserted bubbles.
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      bubble_cnt_o <= '0;
    end else if (load_bubble && !cnt_sat) begin
      bubble_cnt_o <= bubble_cnt_o + 1'b1;
    end
  end

  // Bubbles clear reg_waddr_o, so the EXE rd is 0 whenever valid_o is 0.
  assign exe_rd_o = reg_waddr_o;

endmodule

// File: tb/tb_id_exe.sv
// Directed testbench for id_exe (counter narrowed to 4 bits to reach saturation).
module tb_id_exe;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        stall_id_i, stall_exe_i, flush_i;
  logic [31:0] inst_i, inst_addr_i, op1_i, op2_i;
  logic        reg_we_i;
  logic [4:0]  reg_waddr_i;
  logic [31:0] inst_o, inst_addr_o, op1_o, op2_o;
  logic        reg_we_o, valid_o, pre_inst_is_load_o;
  logic [4:0]  reg_waddr_o, exe_rd_o;
  logic [3:0]  bubble_cnt_o;

  int compared   = 0;
  int mismatched = 0;

  id_exe #(.CNT_WIDTH(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .stall_id_i(stall_id_i), .stall_exe_i(stall_exe_i),
    .flush_i(flush_i), .inst_i(inst_i), .inst_addr_i(inst_addr_i), .op1_i(op1_i),
    .op2_i(op2_i), .reg_we_i(reg_we_i), .reg_waddr_i(reg_waddr_i), .inst_o(inst_o),
    .inst_addr_o(inst_addr_o), .op1_o(op1_o), .op2_o(op2_o), .reg_we_o(reg_we_o),
    .reg_waddr_o(reg_waddr_o), .valid_o(valid_o), .pre_inst_is_load_o(pre_inst_is_load_o),
    .exe_rd_o(exe_rd_o), .bubble_cnt_o(bubble_cnt_o)
  );

  // 10 ns core clock.
  always #5 clk_i = ~clk_i;

  // Advance one edge and settle away from it.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic [31:0] inst, input logic [31:0] pc, input logic [31:0] a,
                       input logic [31:0] b, input logic we, input logic [4:0] rd);
    inst_i = inst; inst_addr_i = pc; op1_i = a; op2_i = b; reg_we_i = we; reg_waddr_i = rd;
  endtask

  task automatic test_reset();
    rst_i = 1'b0; stall_id_i = 1'b0; stall_exe_i = 1'b0; flush_i = 1'b0;
    drive(32'h0000A283, 32'h44, 32'h7, 32'h9, 1'b1, 5'd5);
    tick(); tick();
    compared++; if (inst_o !== 32'h13) begin mismatched++; $display("[TB] FAIL reset_inst got %h exp %h", inst_o, 32'h13); end
    compared++; if (valid_o !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_valid got %b exp 0", valid_o); end
    compared++; if (bubble_cnt_o !== 4'd0) begin mismatched++; $display("[TB] FAIL reset_cnt got %0d exp 0", bubble_cnt_o); end
    compared++; if ({inst_addr_o, op1_o, op2_o} !== 96'd0) begin mismatched++; $display("[TB] FAIL reset_data got %h %h %h exp 0", inst_addr_o, op1_o, op2_o); end
    compared++; if ({reg_we_o, reg_waddr_o, exe_rd_o, pre_inst_is_load_o} !== 12'd0) begin mismatched++; $display("[TB] FAIL reset_ctrl got %b %0d %0d %b exp 0", reg_we_o, reg_waddr_o, exe_rd_o, pre_inst_is_load_o); end
  endtask

  task automatic test_capture();
    rst_i = 1'b1;
    drive(32'h00500093, 32'h100, 32'd5, 32'd0, 1'b1, 5'd1);
    tick();
    compared++; if (inst_o !== 32'h00500093) begin mismatched++; $display("[TB] FAIL cap_inst got %h exp %h", inst_o, 32'h00500093); end
    compared++; if (inst_addr_o !== 32'h100 || op1_o !== 32'd5 || op2_o !== 32'd0) begin mismatched++; $display("[TB] FAIL cap_data got %h %h %h exp 100 5 0", inst_addr_o, op1_o, op2_o); end
    compared++; if (valid_o !== 1'b1 || reg_we_o !== 1'b1 || reg_waddr_o !== 5'd1) begin mismatched++; $display("[TB] FAIL cap_ctrl got v=%b we=%b rd=%0d exp 1 1 1", valid_o, reg_we_o, reg_waddr_o); end
    compared++; if (pre_inst_is_load_o !== 1'b0) begin mismatched++; $display("[TB] FAIL cap_load got %b exp 0", pre_inst_is_load_o); end
    // A captured NOP is a real instruction and is not counted as a bubble.
    drive(32'h00000013, 32'h104, 32'd0, 32'd0, 1'b1, 5'd0);
    tick();
    compared++; if (valid_o !== 1'b1 || inst_o !== 32'h13 || bubble_cnt_o !== 4'd0) begin mismatched++; $display("[TB] FAIL cap_nop got v=%b inst=%h cnt=%0d exp 1 13 0", valid_o, inst_o, bubble_cnt_o); end
  endtask

  task automatic test_load_use();
    // Loads to x0 or without write enable are not load-use hazards.
    drive(32'h0000A003, 32'h108, 32'd0, 32'd0, 1'b1, 5'd0);
    tick();
    compared++; if (pre_inst_is_load_o !== 1'b0) begin mismatched++; $display("[TB] FAIL load_x0 got %b exp 0", pre_inst_is_load_o); end
    drive(32'h0000A283, 32'h10C, 32'd0, 32'd0, 1'b0, 5'd5);
    tick();
    compared++; if (pre_inst_is_load_o !== 1'b0) begin mismatched++; $display("[TB] FAIL load_nowe got %b exp 0", pre_inst_is_load_o); end
    drive(32'h0000A283, 32'h110, 32'h200, 32'd0, 1'b1, 5'd5);
    tick();
    compared++; if (pre_inst_is_load_o !== 1'b1 || exe_rd_o !== 5'd5) begin mismatched++; $display("[TB] FAIL load_flag got %b rd=%0d exp 1 5", pre_inst_is_load_o, exe_rd_o); end
    stall_id_i = 1'b1;
    drive(32'h001283B3, 32'h114, 32'd1, 32'd2, 1'b1, 5'd7);
    tick();
    compared++; if (valid_o !== 1'b0 || pre_inst_is_load_o !== 1'b0 || exe_rd_o !== 5'd0 || inst_o !== 32'h13) begin mismatched++; $display("[TB] FAIL lu_bubble got v=%b ld=%b rd=%0d inst=%h exp 0 0 0 13", valid_o, pre_inst_is_load_o, exe_rd_o, inst_o); end
    compared++; if (bubble_cnt_o !== 4'd1) begin mismatched++; $display("[TB] FAIL lu_cnt got %0d exp 1", bubble_cnt_o); end
    stall_id_i = 1'b0;
    tick();
    compared++; if (valid_o !== 1'b1 || inst_o !== 32'h001283B3 || exe_rd_o !== 5'd7 || bubble_cnt_o !== 4'd1) begin mismatched++; $display("[TB] FAIL lu_resume got v=%b inst=%h rd=%0d cnt=%0d exp 1 001283b3 7 1", valid_o, inst_o, exe_rd_o, bubble_cnt_o); end
  endtask

  task automatic test_exe_stall();
    stall_exe_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      stall_id_i = (i == 1);
      drive(32'h00A00513 + i, 32'h200 + 4 * i, i, i + 1, 1'b1, 5'd10 + 5'(i));
      tick();
      compared++; if (inst_o !== 32'h001283B3 || inst_addr_o !== 32'h114 || op2_o !== 32'd2 || valid_o !== 1'b1 || bubble_cnt_o !== 4'd1) begin mismatched++; $display("[TB] FAIL hold_%0d got inst=%h pc=%h op2=%h v=%b cnt=%0d exp 001283b3 114 2 1 1", i, inst_o, inst_addr_o, op2_o, valid_o, bubble_cnt_o); end
    end
    stall_exe_i = 1'b0; stall_id_i = 1'b0;
    drive(32'h00B00593, 32'h300, 32'h33, 32'h44, 1'b1, 5'd11);
    tick();
    compared++; if (inst_o !== 32'h00B00593 || inst_addr_o !== 32'h300 || op1_o !== 32'h33 || reg_waddr_o !== 5'd11) begin mismatched++; $display("[TB] FAIL hold_release got inst=%h pc=%h op1=%h rd=%0d exp 00b00593 300 33 11", inst_o, inst_addr_o, op1_o, reg_waddr_o); end
  endtask

  task automatic test_flush_stall();
    flush_i = 1'b1; stall_exe_i = 1'b1; stall_id_i = 1'b1;
    tick();
    compared++; if (valid_o !== 1'b0 || inst_o !== 32'h13 || op1_o !== 32'd0 || reg_we_o !== 1'b0) begin mismatched++; $display("[TB] FAIL flush_bubble got v=%b inst=%h op1=%h we=%b exp 0 13 0 0", valid_o, inst_o, op1_o, reg_we_o); end
    compared++; if (bubble_cnt_o !== 4'd2) begin mismatched++; $display("[TB] FAIL flush_cnt got %0d exp 2", bubble_cnt_o); end
    flush_i = 1'b0; stall_exe_i = 1'b0; stall_id_i = 1'b0;
  endtask

  task automatic test_saturation();
    stall_id_i = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (i == 12) begin
        compared++; if (bubble_cnt_o !== 4'd15) begin mismatched++; $display("[TB] FAIL sat_reach got %0d exp 15", bubble_cnt_o); end
      end
    end
    compared++; if (bubble_cnt_o !== 4'd15) begin mismatched++; $display("[TB] FAIL sat_hold got %0d exp 15", bubble_cnt_o); end
    rst_i = 1'b0;
    tick();
    compared++; if (bubble_cnt_o !== 4'd0 || valid_o !== 1'b0) begin mismatched++; $display("[TB] FAIL sat_reset got cnt=%0d v=%b exp 0 0", bubble_cnt_o, valid_o); end
    rst_i = 1'b1;
    tick();
    compared++; if (bubble_cnt_o !== 4'd1) begin mismatched++; $display("[TB] FAIL sat_restart got %0d exp 1", bubble_cnt_o); end
    stall_id_i = 1'b0;
  endtask

  // Run every scenario in order, then report.
  initial begin
    test_reset();
    test_capture();
    test_load_use();
    test_exe_stall();
    test_flush_stall();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
